alu_issue_stage: RTL and testbench

Decode-and-operand-fetch stage directly upstream of the 32-bit ALU. It accepts one MIPS-subset instruction per handshake and maps opcode/funct to the 3-bit ALUControl encoding (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT). It reads both operands from an internal 32x32 register file and presents ALUControl/A/B in an output pipeline register. ALU results come back through a write-back port into the register file.

---
 rtl/alu_issue_stage_if.sv | 42 ++++
 rtl/alu_issue_stage.sv | 128 ++++++++++++
 tb/tb_alu_issue_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Handshake, operand and write-back bundle for alu_issue_stage.
// The DUT side uses the slave modport; the driver side uses master.
interface alu_issue_stage_if;
  logic        In_Valid;
  logic        In_Ready;
  logic [5:0]  In_Op;
  logic [5:0]  In_Funct;
  logic [4:0]  In_Rs;
  logic [4:0]  In_Rt;
  logic [4:0]  In_Rd;
  logic [15:0] In_Imm;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [2:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Out_Rd;
  logic        WB_En;
  logic [4:0]  WB_Addr;
  logic [31:0] WB_Data;
  logic        Illegal;

  modport slave (
    input  In_Valid, In_Op, In_Funct,
    input  In_Rs, In_Rt, In_Rd, In_Imm,
    input  Out_Ready,
    input  WB_En, WB_Addr, WB_Data,
    output In_Ready, Out_Valid,
    output ALUControl, A, B, Out_Rd,
    output Illegal
  );

  modport master (
    output In_Valid, In_Op, In_Funct,
    output In_Rs, In_Rt, In_Rd, In_Imm,
    output Out_Ready,
    output WB_En, WB_Addr, WB_Data,
    input  In_Ready, Out_Valid,
    input  ALUControl, A, B, Out_Rd,
    input  Illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS-subset decode + operand fetch feeding the ALU.
// Define ALU_ISSUE_BYPASS_EN to forward same-cycle write-back into reads.
module alu_issue_stage (
  input  logic              Clk,
  input  logic              Reset,
  alu_issue_stage_if.slave  bus
);

  logic [31:0] r_rf [32];
  logic        r_valid;
  logic [2:0]  r_ctrl;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic        r_ill;

  logic        w_rtype;
  logic        w_addi;
  logic        w_slti;
  logic        w_andi;
  logic        w_ori;
  logic        w_legal;
  logic [2:0]  w_ctrl;
  logic [31:0] w_imm;
  logic        w_use_imm;
  logic [4:0]  w_dst;
  logic [31:0] w_rs_raw;
  logic [31:0] w_rt_raw;
  logic [31:0] w_a;
  logic [31:0] w_rt;
  logic        w_ready;
  logic        w_acc;

  assign w_rtype = bus.In_Op == 6'b000000;
  assign w_addi  = bus.In_Op == 6'b001000;
  assign w_slti  = bus.In_Op == 6'b001010;
  assign w_andi  = bus.In_Op == 6'b001100;
  assign w_ori   = bus.In_Op == 6'b001101;

  always_comb begin
    w_legal   = 1'b1;
    w_ctrl    = 3'b000;
    w_imm     = {16'h0000, bus.In_Imm};
    w_use_imm = 1'b1;
    w_dst     = bus.In_Rt;
    unique case (1'b1)
      w_rtype: begin
        w_use_imm = 1'b0;
        w_dst     = bus.In_Rd;
        case (bus.In_Funct)
          6'b100100: w_ctrl = 3'b000;
          6'b100101: w_ctrl = 3'b001;
          6'b100000: w_ctrl = 3'b010;
          6'b100010: w_ctrl = 3'b110;
          6'b101010: w_ctrl = 3'b111;
          default:   w_legal = 1'b0;
        endcase
      end
      w_addi: begin
        w_ctrl = 3'b010;
        w_imm  = {{16{bus.In_Imm[15]}}, bus.In_Imm};
      end
      w_slti: begin
        w_ctrl = 3'b111;
        w_imm  = {{16{bus.In_Imm[15]}}, bus.In_Imm};
      end
      w_andi: w_ctrl = 3'b000;
      w_ori:  w_ctrl = 3'b001;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_rs_raw = (bus.In_Rs == 5'd0) ? 32'd0 : r_rf[bus.In_Rs];
  assign w_rt_raw = (bus.In_Rt == 5'd0) ? 32'd0 : r_rf[bus.In_Rt];

`ifdef ALU_ISSUE_BYPASS_EN
  // Forward a write-back landing on this edge so no bubble is needed.
  assign w_a = (bus.WB_En && bus.WB_Addr == bus.In_Rs &&
                bus.In_Rs != 5'd0) ? bus.WB_Data : w_rs_raw;
  assign w_rt = (bus.WB_En && bus.WB_Addr == bus.In_Rt &&
                 bus.In_Rt != 5'd0) ? bus.WB_Data : w_rt_raw;
`else
  assign w_a  = w_rs_raw;
  assign w_rt = w_rt_raw;
`endif

  assign w_ready = !Reset && (!r_valid || bus.Out_Ready);
  assign w_acc   = bus.In_Valid && w_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (bus.WB_En && bus.WB_Addr != 5'd0) begin
      r_rf[bus.WB_Addr] <= bus.WB_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= 3'b000;
      r_a     <= '0;
      r_b     <= '0;
      r_rd    <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_ill <= w_acc && !w_legal;
      if (w_acc && w_legal) begin
        r_valid <= 1'b1;
        r_ctrl  <= w_ctrl;
        r_a     <= w_a;
        r_b     <= w_use_imm ? w_imm : w_rt;
        r_rd    <= w_dst;
      end else if (bus.Out_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.In_Ready   = w_ready;
  assign bus.Out_Valid  = r_valid;
  assign bus.ALUControl = r_ctrl;
  assign bus.A          = r_a;
  assign bus.B          = r_b;
  assign bus.Out_Rd     = r_rd;
  assign bus.Illegal    = r_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed + random bench for alu_issue_stage with a queue-based model.
// Expected operand reads follow ALU_ISSUE_BYPASS_EN when defined.
module tb_alu_issue_stage;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          legal;
    logic [2:0]  ctrl;
    bit          use_imm;
    logic [31:0] bimm;
    bit          dst_rt;
  } dec_t;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } entry_t;

  logic [31:0] m_rf [32];
  entry_t      q [$];
  bit          m_ill;
  int          total  = 0;
  int          passed = 0;
  int          failed = 0;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic dec_t m_decode(logic [5:0] op, logic [5:0] fn,
                                    logic [15:0] imm);
    dec_t d;
    d.legal = 1; d.ctrl = 3'd0; d.use_imm = 1; d.dst_rt = 1;
    d.bimm = {16'h0, imm};
    if (op == 6'h00) begin
      d.use_imm = 0;
      d.dst_rt  = 0;
      case (fn)
        6'h24: d.ctrl = 3'd0;
        6'h25: d.ctrl = 3'd1;
        6'h20: d.ctrl = 3'd2;
        6'h22: d.ctrl = 3'd6;
        6'h2A: d.ctrl = 3'd7;
        default: d.legal = 0;
      endcase
    end else begin
      case (op)
        6'h08: begin d.ctrl = 3'd2; d.bimm = 32'($signed(imm)); end
        6'h0A: begin d.ctrl = 3'd7; d.bimm = 32'($signed(imm)); end
        6'h0C: d.ctrl = 3'd0;
        6'h0D: d.ctrl = 3'd1;
        default: d.legal = 0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] r);
    if (r == 0) return 32'd0;
    if (BYP && bus.WB_En && bus.WB_Addr == r) return bus.WB_Data;
    return m_rf[r];
  endfunction

  task automatic step();
    dec_t   d;
    entry_t e;
    bit     rdy;
    bit     acc;
    #1;
    rdy = !Reset && (q.size() == 0 || bus.Out_Ready);
    chk("in_ready", 32'(bus.In_Ready), 32'(rdy));
    if (Reset) begin
      q.delete();
      foreach (m_rf[i]) m_rf[i] = 32'd0;
      m_ill = 0;
    end else begin
      acc = bus.In_Valid && rdy;
      d = m_decode(bus.In_Op, bus.In_Funct, bus.In_Imm);
      e.ctrl = d.ctrl;
      e.a    = m_read(bus.In_Rs);
      e.b    = d.use_imm ? d.bimm : m_read(bus.In_Rt);
      e.rd   = d.dst_rt ? bus.In_Rt : bus.In_Rd;
      if (q.size() != 0 && bus.Out_Ready) void'(q.pop_front());
      if (acc && d.legal) q.push_back(e);
      m_ill = acc && !d.legal;
      if (bus.WB_En && bus.WB_Addr != 0) m_rf[bus.WB_Addr] = bus.WB_Data;
    end
    @(posedge Clk);
    #1;
    chk("out_valid", 32'(bus.Out_Valid), 32'(q.size() != 0));
    chk("illegal", 32'(bus.Illegal), 32'(m_ill));
    if (q.size() != 0) begin
      chk("ctrl", 32'(bus.ALUControl), 32'(q[0].ctrl));
      chk("a", bus.A, q[0].a);
      chk("b", bus.B, q[0].b);
      chk("rd", 32'(bus.Out_Rd), 32'(q[0].rd));
    end
  endtask

  task automatic instr(logic [5:0] op, logic [5:0] fn, logic [4:0] rs,
                       logic [4:0] rt, logic [4:0] rd, logic [15:0] imm);
    bus.In_Valid = 1'b1;
    bus.In_Op    = op;
    bus.In_Funct = fn;
    bus.In_Rs    = rs;
    bus.In_Rt    = rt;
    bus.In_Rd    = rd;
    bus.In_Imm   = imm;
  endtask

  logic [5:0] ops [9];
  logic [5:0] fns [9];

  initial begin
    ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D};
    fns = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00};
    foreach (m_rf[i]) m_rf[i] = 32'd0;
    m_ill = 0;
    Reset = 1'b1;
    bus.Out_Ready = 1'b1;
    bus.WB_En = 1'b0;
    bus.WB_Addr = '0;
    bus.WB_Data = '0;
    instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);

    // reset held two cycles with an instruction offered
    step();
    step();
    chk("rst_a", bus.A, 32'd0);
    chk("rst_b", bus.B, 32'd0);
    chk("rst_ctrl", 32'(bus.ALUControl), 32'd0);
    chk("rst_rd", 32'(bus.Out_Rd), 32'd0);
    Reset = 1'b0;
    bus.In_Valid = 1'b0;
    step();

    bus.WB_En = 1'b1;
    bus.WB_Addr = 5'd1;
    bus.WB_Data = 32'h14071757;
    step();
    bus.WB_Addr = 5'd2;
    bus.WB_Data = 32'h14071758;
    step();
    bus.WB_En = 1'b0;

    instr(6'h00, 6'h22, 5'd1, 5'd2, 5'd3, 16'h0);
    step();
    chk("sub_ctrl", 32'(bus.ALUControl), 32'd6);
    chk("sub_a", bus.A, 32'h14071757);
    chk("sub_b", bus.B, 32'h14071758);
    chk("sub_rd", 32'(bus.Out_Rd), 32'd3);

    instr(6'h08, 6'h00, 5'd0, 5'd5, 5'd0, 16'hFFFF);
    step();
    chk("addi_ctrl", 32'(bus.ALUControl), 32'd2);
    chk("addi_a", bus.A, 32'd0);
    chk("addi_b", bus.B, 32'hFFFFFFFF);
    instr(6'h0C, 6'h00, 5'd0, 5'd5, 5'd0, 16'hFFFF);
    step();
    chk("andi_ctrl", 32'(bus.ALUControl), 32'd0);
    chk("andi_b", bus.B, 32'h0000FFFF);

    // stall: ANDI result held while ADD waits
    bus.Out_Ready = 1'b0;
    instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd6, 16'h0);
    repeat (3) begin
      step();
      chk("stall_b", bus.B, 32'h0000FFFF);
    end
    bus.Out_Ready = 1'b1;
    step();
    chk("unstall_rd", 32'(bus.Out_Rd), 32'd6);
    chk("unstall_a", bus.A, 32'h14071757);
    bus.In_Valid = 1'b0;
    step();

    instr(6'h00, 6'h03, 5'd1, 5'd2, 5'd9, 16'h0);
    step();
    chk("ill_pulse", 32'(bus.Illegal), 32'd1);
    bus.In_Valid = 1'b0;
    bus.WB_En = 1'b1;
    bus.WB_Addr = 5'd0;
    bus.WB_Data = 32'd5;
    step();
    chk("ill_gone", 32'(bus.Illegal), 32'd0);
    bus.WB_En = 1'b0;
    instr(6'h00, 6'h25, 5'd0, 5'd0, 5'd7, 16'h0);
    step();
    chk("r0_a", bus.A, 32'd0);
    chk("r0_b", bus.B, 32'd0);
    bus.In_Valid = 1'b0;
    step();

    bus.WB_En = 1'b1;
    bus.WB_Addr = 5'd4;
    bus.WB_Data = 32'hDEADBEEF;
    instr(6'h00, 6'h25, 5'd4, 5'd0, 5'd8, 16'h0);
    step();
    chk("bypass_a", bus.A, BYP ? 32'hDEADBEEF : 32'd0);
    bus.WB_En = 1'b0;
    bus.In_Valid = 1'b0;
    step();

    for (int n = 0; n < 400; n++) begin
      int k;
      k = int'($urandom_range(0, 8));
      Reset = ($urandom_range(0, 99) == 0);
      bus.Out_Ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 6) == 0)
        instr(6'($urandom), 6'($urandom), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom));
      else
        instr(ops[k], fns[k], 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom));
      bus.In_Valid = ($urandom_range(0, 3) != 0);
      bus.WB_En = $urandom_range(0, 1) == 1;
      bus.WB_Addr = 5'($urandom_range(0, 7));
      bus.WB_Data = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
